// File: rtl/uart16550_pkg.sv
// uart16550_pkg: shared register types, interrupt ids and decode helpers for the UART16550 core.
package uart16550_pkg;

    typedef struct packed {
        logic [3:0] rsvd;
        logic       edssi;
        logic       elsi;
        logic       etbei;
        logic       erbfi;
    } ier_t;

    typedef struct packed {
        logic       dlab;
        logic       bc;
        logic       sp;
        logic       eps;
        logic       pen;
        logic       stb;
        logic [1:0] wls;
    } lcr_t;

    typedef enum logic [1:0] {
        RXTRIGGER01 = 2'b00,
        RXTRIGGER04 = 2'b01,
        RXTRIGGER08 = 2'b10,
        RXTRIGGER14 = 2'b11
    } rxtrigger_t;

    typedef enum logic [2:0] {
        IID_RLS  = 3'b011,
        IID_RDA  = 3'b010,
        IID_CTO  = 3'b110,
        IID_THRE = 3'b001,
        IID_MS   = 3'b000
    } irq_id_t;

    function automatic int rx_trigger_level(input rxtrigger_t t);
        return t == RXTRIGGER01 ? 1 : t == RXTRIGGER04 ? 4 : t == RXTRIGGER08 ? 8 : 14;
    endfunction

    // start + (5+wls) data + parity + stop, where 1.5 stop bits rounds up to 2
    function automatic logic [3:0] char_bits(input lcr_t l);
        return 4'd7 + {2'b00, l.wls} + {3'b000, l.pen} + {3'b000, l.stb};
    endfunction

endpackage

// File: rtl/uart16550_rx_timeout.sv
// uart16550_rx_timeout: RX character-timeout counter, limit compare and pending latch.
module uart16550_rx_timeout
    import uart16550_pkg::*;
#(
    parameter  int FIFO_DEPTH    = 16,
    parameter  int TIMEOUT_CHARS = 4,
    localparam int L             = $clog2(FIFO_DEPTH) + 1
) (
    input  logic         PCLK,
    input  logic         PRESETn,
    input  lcr_t         lcr,
    input  logic         fifo_ena,
    input  logic [L-1:0] rx_level,
    input  logic         rx_push,
    input  logic         rbr_rd,
    input  logic         bit_tick,
    output logic         timeout_pend,
    output logic         timeout_pend_d
);
    logic [5:0] cnt, cnt_d, limit;
    logic       ena_q, ena_chg, empty;
    int         lim_full;

    assign empty   = rx_level == '0;
    assign ena_chg = fifo_ena != ena_q;

    // A limit lowered mid-count just leaves the counter parked at or above it
    always_comb begin
        lim_full       = TIMEOUT_CHARS * int'(char_bits(lcr));
        limit          = lim_full > 48 ? 6'd48 : lim_full[5:0];
        cnt_d          = (rx_push | rbr_rd | empty | ~fifo_ena | ena_chg) ? 6'd0 :
                         (bit_tick && cnt < limit) ? cnt + 6'd1 : cnt;
        timeout_pend_d = (rx_push | rbr_rd | empty | ena_chg) ? 1'b0 : (timeout_pend | (cnt >= limit));
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            cnt          <= '0;
            timeout_pend <= 1'b0;
            ena_q        <= 1'b0;
        end else begin
            cnt          <= cnt_d;
            timeout_pend <= timeout_pend_d;
            ena_q        <= fifo_ena;
        end
    end

endmodule

// File: rtl/uart16550_irq_ctrl.sv
// uart16550_irq_ctrl: gates the five 16550 interrupt sources with IER, prioritises them
// into registered IIR id/pending fields and irq, and owns the THRE latch.
module uart16550_irq_ctrl
    import uart16550_pkg::*;
#(
    parameter  int FIFO_DEPTH    = 16,
    parameter  int TIMEOUT_CHARS = 4,
    localparam int L             = $clog2(FIFO_DEPTH) + 1
) (
    input  logic         PCLK,
    input  logic         PRESETn,
    input  ier_t         ier,
    input  lcr_t         lcr,
    input  logic         fifo_ena,
    input  rxtrigger_t   rx_trigger,
    input  logic [L-1:0] rx_level,
    input  logic         rx_push,
    input  logic         rbr_rd,
    input  logic         lsr_err,
    input  logic         lsr_rd,
    input  logic         thre,
    input  logic         thr_wr,
    input  logic         iir_rd,
    input  logic         msr_delta,
    input  logic         bit_tick,
    output logic [2:0]   iir_id,
    output logic         iir_pending_n,
    output logic         irq
);
    localparam int TRIG_MAX = FIFO_DEPTH < 16 ? FIFO_DEPTH - 2 : 14;

    logic    thre_q, etbei_q, thre_pend, thre_pend_d;
    logic    timeout_pend, timeout_pend_d;
    logic    rls, rda, cto, thr_src, ms, pend_n_d, unused;
    int      trig;
    irq_id_t id_d;

    // LSR reads clear lsr_err upstream; nothing is held here for it
    assign unused = lsr_rd;

    uart16550_rx_timeout #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .TIMEOUT_CHARS(TIMEOUT_CHARS)
    ) u_timeout (
        .PCLK          (PCLK),
        .PRESETn       (PRESETn),
        .lcr           (lcr),
        .fifo_ena      (fifo_ena),
        .rx_level      (rx_level),
        .rx_push       (rx_push),
        .rbr_rd        (rbr_rd),
        .bit_tick      (bit_tick),
        .timeout_pend  (timeout_pend),
        .timeout_pend_d(timeout_pend_d)
    );

    // Sources use post-update latch values so the outputs track same-cycle set/clear
    always_comb begin
        trig        = rx_trigger_level(rx_trigger) > TRIG_MAX ? TRIG_MAX : rx_trigger_level(rx_trigger);
        thre_pend_d = ((thre & ~thre_q) | (ier.etbei & ~etbei_q & thre)) ? 1'b1 :
                      (thr_wr | (iir_rd & ~iir_pending_n & (iir_id == IID_THRE))) ? 1'b0 : thre_pend;
        rls         = ier.elsi & lsr_err;
        rda         = ier.erbfi & (fifo_ena ? int'(rx_level) >= trig : rx_level != '0);
        cto         = ier.erbfi & fifo_ena & timeout_pend_d;
        thr_src     = ier.etbei & thre_pend_d;
        ms          = ier.edssi & msr_delta;
        id_d        = rls ? IID_RLS : rda ? IID_RDA : cto ? IID_CTO : thr_src ? IID_THRE : IID_MS;
        pend_n_d    = ~(rls | rda | cto | thr_src | ms);
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            thre_q        <= 1'b0;
            etbei_q       <= 1'b0;
            thre_pend     <= 1'b0;
            iir_id        <= 3'b000;
            iir_pending_n <= 1'b1;
            irq           <= 1'b0;
        end else begin
            thre_q        <= thre;
            etbei_q       <= ier.etbei;
            thre_pend     <= thre_pend_d;
            iir_id        <= id_d;
            iir_pending_n <= pend_n_d;
            irq           <= ~pend_n_d;
        end
    end

endmodule

// File: doc/uart16550_irq_ctrl.md
Name: uart16550_irq_ctrl

Overview:
Interrupt prioritiser and scheduler for the UART16550 core. It collects the five 16550 interrupt sources (line status, RX data available, character timeout, THR empty, modem status) and gates them with IER. It then presents the single highest-priority pending source as the IIR id/pending fields and drives the irq output. The block sits between the RX/TX FIFO datapath and the APB4 register file, and owns the THRE latch and the RX character-timeout counter.

Parameters:
FIFO_DEPTH, 16, RX FIFO depth; level ports are $clog2(FIFO_DEPTH)+1 bits wide
TIMEOUT_CHARS, 4, character times of RX inactivity before a timeout interrupt

Ports:
PCLK  in  1  system clock
PRESETn  in  1  reset, synchronous, active-low
ier  in  8  IER value (ier_t)
lcr  in  8  LCR value (lcr_t); wls/pen/stb size the character time
fifo_ena  in  1  FCR.ena
rx_trigger  in  2  FCR rx_trigger (rxtrigger_t)
rx_level  in  L  RX FIFO fill level
rx_push  in  1  one-cycle pulse: character written into RX FIFO/RBR
rbr_rd  in  1  one-cycle pulse: APB read of RBR
lsr_err  in  1  OR of LSR oe/pe/fe/bi, already latched by LSR logic
lsr_rd  in  1  APB read of LSR
thre  in  1  LSR.thre
thr_wr  in  1  APB write of THR
iir_rd  in  1  APB read of IIR
msr_delta  in  1  OR of MSR dcts/ddsr/teri/ddcd
bit_tick  in  1  one-cycle pulse per serial bit period (16 baud ticks)
iir_id  out  3  iir_t.interrupt_id
iir_pending_n  out  1  iir_t.interrupt_pending; 0 = pending
irq  out  1  registered interrupt request

Behaviour:
- Reset (PRESETn=0 at a PCLK edge): iir_id=000, iir_pending_n=1, irq=0, thre_pend=0, timeout counter=0, timeout_pend=0.
- Gated sources:
  - RLS = ier.elsi & lsr_err
  - RDA = ier.erbfi & (fifo_ena ? rx_level >= trig : rx_level != 0)
  - CTO = ier.erbfi & fifo_ena & timeout_pend
  - THRE = ier.etbei & thre_pend
  - MS = ier.edssi & msr_delta
- Trigger decode: rxtrigger01=1, rxtrigger04=4, rxtrigger08=8, rxtrigger14=14 (clamped to FIFO_DEPTH-2 when FIFO_DEPTH<16).
- Priority, highest first, as iir_id: RLS=011, RDA=010, CTO=110, THRE=001, MS=000. No source: iir_id=000, iir_pending_n=1.
- iir_id, iir_pending_n and irq are registered: one cycle of latency from a source change to the outputs. irq = ~iir_pending_n.
- THRE latch:
  - Set on a thre 0->1 edge, or on an ier.etbei 0->1 edge while thre=1.
  - Cleared by thr_wr.
  - Cleared by iir_rd only when the registered iir_id is 001 with pending in that same cycle.
  - If set and clear occur in the same cycle, set wins.
- Character timeout (sub-module):
  - char_bits = 1 + (5 + wls) + pen + (stb ? 2 : 1); 1.5 stop bits rounds to 2.
  - Limit = TIMEOUT_CHARS * char_bits, 6-bit counter, maximum 48.
  - Counter clears on rx_push, rbr_rd, rx_level==0, or fifo_ena==0. Otherwise it increments on bit_tick and saturates at the limit.
  - timeout_pend sets when count == limit.
  - timeout_pend clears on rbr_rd, rx_push, or rx_level==0.
  - Changing lcr mid-count takes effect on the next compare and never wraps.
- RLS, RDA and MS are level-based. They clear when lsr_rd / a FIFO drain / an MSR read clears the upstream status; this block holds no state for them.
- Simultaneous events: the priority mux is evaluated after same-cycle latch updates. The registered output reflects the post-update state.
- fifo_ena 0->1 or 1->0: the timeout state is cleared in that cycle.

Decomposition:
- Add to uart16550_pkg:
  - typedef enum logic [2:0] irq_id_t: IID_RLS=3'b011, IID_RDA=3'b010, IID_CTO=3'b110, IID_THRE=3'b001, IID_MS=3'b000.
  - Function rx_trigger_level(rxtrigger_t) returning an integer.
  - Function char_bits(lcr_t) returning 4 bits.
- Sub-module uart16550_rx_timeout: counter, limit compare and timeout_pend, outputs timeout_pend.

Test Plan:
- Reset, no sources; then ier=8'h02 with thre rising 0->1 → irq=1 and iir_id=001 one cycle later. iir_rd → irq=0 next cycle. A second thre edge re-asserts irq.
- fifo_ena=1, rx_trigger=rxtrigger04, ier=8'h01; push 3 chars → no irq. 4th push → iir_id=010. rbr_rd drops rx_level to 3 → iir_pending_n=1.
- lcr wls=11, pen=0, stb=0 (10 bits); rx_level=2, ier=8'h01, no push/read. Pulse bit_tick 39 times → no irq. 40th pulse → iir_id=110. rbr_rd → cleared.
- lsr_err, RDA, THRE and msr_delta all active, ier=8'h0F → iir_id=011. Drop lsr_err → 010. Drain RX → 001. iir_rd → 000. Drop msr_delta → iir_pending_n=1.
- THRE pending; thr_wr and a thre 0->1 edge in the same cycle → thre_pend stays set and iir_id remains 001.
- CTO pending, then PRESETn=0 for one edge → all outputs at reset values, counter 0. No irq until a full 40 ticks elapse again.
